// File: rtl/l2_request_arbiter_pkg.sv
// Shared types for the per-core L2 request path: request/response packets and
// the requester unit encodings used by the arbiter and its round-robin core.
package l2_request_arbiter_pkg;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 32;
  localparam int CORE_W  = 4;

  typedef enum logic [1:0] {
    UNIT_ICACHE = 2'd0,
    UNIT_DCACHE = 2'd1,
    UNIT_STBUF  = 2'd2
  } l2_unit_e;

  typedef struct packed {
    logic              valid;
    l2_unit_e          unit;
    logic              store;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } l2req_packet_t;

  typedef struct packed {
    logic              valid;
    logic [CORE_W-1:0] core;
    l2_unit_e          unit;
    logic [DATA_W-1:0] data;
  } l2rsp_packet_t;

endpackage

// File: rtl/l2_request_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among requests, highest priority to the
// index after the last winner; priority only advances when update_lru is set.
module l2_request_arbiter_rr #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] request,
  input  logic         update_lru,
  output logic [N-1:0] grant_oh
);

  logic [N-1:0]   prio_q, prio_d;
  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_gnt;

  // Doubled-vector trick: subtracting the priority one-hot clears everything
  // below it, so the first set request at or after prio survives, wrapping.
  assign dbl_req  = {request, request};
  assign dbl_gnt  = dbl_req & ~(dbl_req - {{N{1'b0}}, prio_q});
  assign grant_oh = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];

  always_comb begin
    prio_d = prio_q;
    if (update_lru && (|grant_oh)) begin
      prio_d = {grant_oh[N-2:0], grant_oh[N-1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= {{(N-1){1'b0}}, 1'b1};
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Per-core L2 request port arbiter: round-robin among icache, dcache and store
// buffer into a registered output stage, throttled by an L2 credit counter.
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int  CORE_ID    = 0,
  parameter int  L2_CREDITS = 4,
  localparam int CREDIT_W   = $clog2(L2_CREDITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  l2req_packet_t       icache_l2req_packet,
  input  l2req_packet_t       dcache_l2req_packet,
  input  l2req_packet_t       stbuf_l2req_packet,
  output logic                icache_l2req_ready,
  output logic                dcache_l2req_ready,
  output logic                stbuf_l2req_ready,
  output l2req_packet_t       l2req_packet,
  input  logic                l2req_ready,
  input  l2rsp_packet_t       l2rsp_packet,
  output logic [CREDIT_W-1:0] credits_available
);

  localparam logic [CREDIT_W-1:0] CREDITS_FULL = CREDIT_W'(L2_CREDITS);

  l2req_packet_t        out_q, out_d;
  logic [CREDIT_W-1:0]  credits_q, credits_d;
  logic [NUM_REQ-1:0]   request;
  logic [NUM_REQ-1:0]   grant_oh;
  l2req_packet_t        winner_pkt;
  logic                 empty, draining, can_capture, capture, credit_inc;
  logic                 unused_rsp_fields;

  assign request = {stbuf_l2req_packet.valid, dcache_l2req_packet.valid,
                    icache_l2req_packet.valid};

  // Capture is gated by the registered credit count only, so a response in
  // the same cycle cannot unblock a stalled request until the next cycle.
  assign empty       = !out_q.valid;
  assign draining    = out_q.valid && l2req_ready;
  assign can_capture = (empty || draining) && (credits_q != '0);
  assign capture     = can_capture && (|request);

  assign credit_inc = l2rsp_packet.valid && (l2rsp_packet.core == CORE_W'(CORE_ID));
  assign unused_rsp_fields = ^{l2rsp_packet.unit, l2rsp_packet.data};

  l2_request_arbiter_rr #(
    .N (NUM_REQ)
  ) u_rr (
    .clk        (clk),
    .reset      (reset),
    .request    (request),
    .update_lru (capture),
    .grant_oh   (grant_oh)
  );

  assign icache_l2req_ready = capture && grant_oh[0];
  assign dcache_l2req_ready = capture && grant_oh[1];
  assign stbuf_l2req_ready  = capture && grant_oh[2];

  always_comb begin
    winner_pkt = icache_l2req_packet;
    if (grant_oh[1]) winner_pkt = dcache_l2req_packet;
    if (grant_oh[2]) winner_pkt = stbuf_l2req_packet;
  end

  always_comb begin
    out_d = out_q;
    if (capture) begin
      out_d = winner_pkt;
    end else if (draining) begin
      out_d = '0;
    end
  end

  always_comb begin
    credits_d = credits_q;
    unique case ({capture, credit_inc})
      2'b10:   credits_d = credits_q - CREDIT_W'(1);
      2'b01:   credits_d = credits_q + CREDIT_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      credits_q <= CREDITS_FULL;
    end else begin
      out_q     <= out_d;
      credits_q <= credits_d;
    end
  end

  assign l2req_packet      = out_q;
  assign credits_available = credits_q;

  a_credit_max: assert property (@(posedge clk) disable iff (reset)
    credits_q <= CREDITS_FULL);
  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (reset)
    !(credit_inc && (credits_q == CREDITS_FULL)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(capture && (credits_q == '0)));
  a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0({stbuf_l2req_ready, dcache_l2req_ready, icache_l2req_ready}));

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Bench for l2_request_arbiter: per-requester packet queues, a cycle model of
// the arbiter, and a scoreboard of captured packets checked as L2 accepts them.
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  localparam int CORE_ID    = 2;
  localparam int L2_CREDITS = 4;
  localparam int CW         = $clog2(L2_CREDITS + 1);

  logic          clk = 1'b0;
  logic          reset;
  l2req_packet_t icache_pkt, dcache_pkt, stbuf_pkt, l2req_pkt;
  logic          icache_rdy, dcache_rdy, stbuf_rdy, l2req_ready;
  l2rsp_packet_t rsp_pkt;
  logic [CW-1:0] credits;

  l2_request_arbiter #(
    .CORE_ID    (CORE_ID),
    .L2_CREDITS (L2_CREDITS)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .icache_l2req_packet (icache_pkt),
    .dcache_l2req_packet (dcache_pkt),
    .stbuf_l2req_packet  (stbuf_pkt),
    .icache_l2req_ready  (icache_rdy),
    .dcache_l2req_ready  (dcache_rdy),
    .stbuf_l2req_ready   (stbuf_rdy),
    .l2req_packet        (l2req_pkt),
    .l2req_ready         (l2req_ready),
    .l2rsp_packet        (rsp_pkt),
    .credits_available   (credits)
  );

  always #5 clk = ~clk;

  l2req_packet_t fifo [3][$];
  l2req_packet_t sb_q [$];

  int            m_ptr, m_credits;
  logic          m_valid;
  l2req_packet_t m_pkt;

  logic l2_rdy;
  bit   auto_rsp, own_rsp_once, foreign_rsp_once;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic l2req_packet_t make_pkt(input int unit, input logic [25:0] addr);
    l2req_packet_t p;
    p         = '0;
    p.valid   = 1'b1;
    p.unit    = l2_unit_e'(unit);
    p.store   = (unit == 2);
    p.address = addr;
    p.data    = $urandom;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) fifo[i].delete();
    sb_q.delete();
    m_ptr     = 0;
    m_credits = L2_CREDITS;
    m_valid   = 1'b0;
    m_pkt     = '0;
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic cycle();
    logic [2:0] exp_rdy;
    int         win;
    logic       drain, cancap, inc;
    l2req_packet_t exp_pkt;

    icache_pkt  = (fifo[0].size() != 0) ? fifo[0][0] : '0;
    dcache_pkt  = (fifo[1].size() != 0) ? fifo[1][0] : '0;
    stbuf_pkt   = (fifo[2].size() != 0) ? fifo[2][0] : '0;
    l2req_ready = l2_rdy;
    rsp_pkt     = '0;
    if ((auto_rsp || own_rsp_once) && m_credits < L2_CREDITS) begin
      rsp_pkt.valid = 1'b1;
      rsp_pkt.core  = CORE_W'(CORE_ID);
      rsp_pkt.data  = $urandom;
    end else if (foreign_rsp_once) begin
      rsp_pkt.valid = 1'b1;
      rsp_pkt.core  = CORE_W'(CORE_ID + 1);
    end
    own_rsp_once     = 1'b0;
    foreign_rsp_once = 1'b0;
    #2;

    drain   = m_valid && l2_rdy;
    cancap  = (!m_valid || drain) && (m_credits != 0);
    win     = -1;
    exp_rdy = 3'b000;
    if (cancap) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_ptr + k) % 3;
        if (win < 0 && fifo[idx].size() != 0) win = idx;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;

    check("ready", {61'd0, stbuf_rdy, dcache_rdy, icache_rdy}, {61'd0, exp_rdy});
    check("out_valid", l2req_pkt.valid, m_valid);
    check("credits", credits, m_credits);
    if (m_valid) check("out_pkt", l2req_pkt, m_pkt);
    if (drain) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_pkt = sb_q.pop_front();
        check("sb_pkt", l2req_pkt, exp_pkt);
        $display("l2 accept unit=%0d addr=%h data=%h", l2req_pkt.unit,
                 l2req_pkt.address, l2req_pkt.data);
      end
    end

    inc = rsp_pkt.valid && (rsp_pkt.core == CORE_W'(CORE_ID));
    if (win >= 0) begin
      m_pkt   = fifo[win].pop_front();
      sb_q.push_back(m_pkt);
      m_valid = 1'b1;
      m_ptr   = (win + 1) % 3;
      m_credits--;
    end else if (drain) begin
      m_valid = 1'b0;
    end
    if (inc) m_credits++;

    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    int n;
    auto_rsp = 1'b1;
    l2_rdy   = 1'b1;
    n = 0;
    while ((m_valid || m_credits != L2_CREDITS || fifo[0].size() != 0 ||
            fifo[1].size() != 0 || fifo[2].size() != 0) && n < 60) begin
      cycle();
      n++;
    end
    if (n >= 60) check("settle_timeout", 1, 0);
    auto_rsp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    icache_pkt = '0; dcache_pkt = '0; stbuf_pkt = '0;
    l2req_ready = 1'b0; rsp_pkt = '0;
    l2_rdy = 1'b1; auto_rsp = 1'b0; own_rsp_once = 1'b0; foreign_rsp_once = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", l2req_pkt.valid, 0);
    check("rst_pkt", l2req_pkt, 0);
    check("rst_credits", credits, L2_CREDITS);
    check("rst_ready", {stbuf_rdy, dcache_rdy, icache_rdy}, 0);
    reset = 1'b0;

    // 1: lone dcache request
    fifo[1].push_back(make_pkt(1, 26'h10));
    cycle();
    check("t1_valid", l2req_pkt.valid, 1);
    check("t1_addr", l2req_pkt.address, 26'h10);
    check("t1_credits", credits, 3);
    settle();

    // 2: all three continuously valid, responses every cycle
    for (int i = 0; i < 6; i++) begin
      for (int u = 0; u < 3; u++) fifo[u].push_back(make_pkt(u, 26'(32'h100 * u + i)));
    end
    auto_rsp = 1'b1;
    repeat (20) cycle();
    settle();

    // 3: L2 stalls with a stbuf packet latched
    l2_rdy = 1'b0;
    fifo[2].push_back(make_pkt(2, 26'h2A0));
    cycle();
    fifo[0].push_back(make_pkt(0, 26'h0A0));
    repeat (5) cycle();
    check("t3_stbuf_held", l2req_pkt.address, 26'h2A0);
    l2_rdy = 1'b1;
    cycle();
    check("t3_icache_next", l2req_pkt.address, 26'h0A0);
    settle();

    // 4: exhaust credits, then return one
    l2_rdy = 1'b1;
    for (int i = 0; i < 5; i++) fifo[0].push_back(make_pkt(0, 26'(32'h400 + i)));
    repeat (4) cycle();
    check("t4_credits_zero", credits, 0);
    repeat (3) cycle();
    check("t4_stalled", fifo[0].size(), 1);
    own_rsp_once = 1'b1;
    cycle();
    check("t4_credit_return", credits, 1);
    cycle();
    check("t4_captured", l2req_pkt.address, 26'h404);

    // 5: simultaneous capture and own response at credits=2; foreign response
    own_rsp_once = 1'b1;
    cycle();
    own_rsp_once = 1'b1;
    cycle();
    check("t5_credits_two", credits, 2);
    fifo[1].push_back(make_pkt(1, 26'h515));
    own_rsp_once = 1'b1;
    cycle();
    check("t5_same_cycle", credits, 2);
    foreign_rsp_once = 1'b1;
    cycle();
    check("t5_foreign", credits, 2);
    settle();

    // 6: asynchronous reset with a valid output and one credit left
    for (int i = 0; i < 3; i++) fifo[0].push_back(make_pkt(0, 26'(32'h600 + i)));
    l2_rdy = 1'b1;
    repeat (3) cycle();
    check("t6_pre_credits", credits, 1);
    check("t6_pre_valid", l2req_pkt.valid, 1);
    l2req_ready = 1'b0;
    #2;
    reset = 1'b1;
    icache_pkt = '0; dcache_pkt = '0; stbuf_pkt = '0; rsp_pkt = '0;
    #1;
    check("t6_async_valid", l2req_pkt.valid, 0);
    check("t6_async_credits", credits, L2_CREDITS);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    fifo[1].push_back(make_pkt(1, 26'h7D0));
    fifo[0].push_back(make_pkt(0, 26'h7C0));
    cycle();
    check("t6_ptr_icache", l2req_pkt.address, 26'h7C0);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
